// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage.
// Drives the delay buffer, butterfly issue, twiddle address and output mux.
module sdf_stage_ctrl #(
    parameter int N_HALF    = 8,
    parameter int BFU_LAT   = 4,
    parameter int TW_AW     = 8,
    parameter int TW_STRIDE = 1,
    localparam int K        = $clog2(N_HALF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             flush,
    output logic             in_ready,
    output logic [K-1:0]     rd_addr,
    output logic             wa_en,
    output logic [K-1:0]     wa_addr,
    output logic             wb_en,
    output logic [K-1:0]     wb_addr,
    output logic             bfu_issue,
    output logic [TW_AW-1:0] tw_addr,
    output logic             out_valid,
    output logic             out_sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BFLY,
        S_DRAIN
    } state_t;

    localparam logic [K-1:0] KMAX = K'(N_HALF - 1);

    state_t         r_state;
    state_t         w_state_n;
    logic [K:0]     r_cnt;
    logic [K:0]     w_cnt_n;
    logic           r_hp;
    logic           w_hp_n;
    logic [K-1:0]   w_k;
    logic           w_acc;
    logic           w_push;
    logic           w_psel;
    logic [K-1:0]   w_paddr;
    logic           w_inflight;
    logic [TW_AW-1:0] w_tw;

    logic           r_pv [BFU_LAT];
    logic           r_ps [BFU_LAT];
    logic [K-1:0]   r_pa [BFU_LAT];

    assign w_k   = r_cnt[K-1:0];
    assign w_tw  = TW_AW'(w_k) * TW_AW'(TW_STRIDE);
    // Gating with rst_n keeps every strobe low while reset is held.
    assign w_acc = in_valid & in_ready & rst_n;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_hp_n    = r_hp;
        in_ready  = (r_state != S_DRAIN);
        rd_addr   = w_k;
        wa_en     = 1'b0;
        wa_addr   = '0;
        bfu_issue = 1'b0;
        tw_addr   = '0;
        w_push    = 1'b0;
        w_psel    = 1'b0;
        w_paddr   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    wa_en     = 1'b1;
                    w_cnt_n   = (K+1)'(1);
                    w_hp_n    = 1'b0;
                    w_state_n = S_FILL;
                end
            end
            S_FILL: begin
                if (w_acc) begin
                    wa_en   = 1'b1;
                    wa_addr = w_k;
                    w_push  = r_hp;
                    w_paddr = r_hp ? w_k : '0;
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_k == KMAX)
                        w_state_n = S_BFLY;
                end else if (flush && r_cnt == '0 && r_hp) begin
                    w_state_n = S_DRAIN;
                end
            end
            S_BFLY: begin
                if (w_acc) begin
                    bfu_issue = 1'b1;
                    tw_addr   = w_tw;
                    w_push    = 1'b1;
                    w_psel    = 1'b1;
                    w_paddr   = w_k;
                    w_cnt_n   = r_cnt + 1'b1;
                    if (w_k == KMAX) begin
                        w_state_n = S_FILL;
                        w_hp_n    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_push  = 1'b1;
                w_paddr = w_k;
                w_cnt_n = r_cnt + 1'b1;
                if (w_k == KMAX) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                    w_hp_n    = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hp    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_hp    <= w_hp_n;
        end
    end

    // Free-running delay line matching the butterfly latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BFU_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_ps[i] <= 1'b0;
                r_pa[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_push;
            r_ps[0] <= w_psel;
            r_pa[0] <= w_paddr;
            for (int i = 1; i < BFU_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < BFU_LAT; i++)
            w_inflight = w_inflight | r_pv[i];
    end

    assign out_valid = r_pv[BFU_LAT-1];
    assign out_sel   = r_ps[BFU_LAT-1];
    assign wb_en     = r_pv[BFU_LAT-1] & r_ps[BFU_LAT-1];
    assign wb_addr   = wb_en ? r_pa[BFU_LAT-1] : '0;
    assign busy      = (r_state != S_IDLE) | w_inflight;

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter N_HALF, default 8: delay-buffer depth (power of 2, SHALL be > BFU_LAT); k = log2(N_HALF) bits.
REQ-002 Parameter BFU_LAT, default 4: clocks from bfu_issue to bfu add/sub results valid (free-running pipeline).
REQ-003 Parameter TW_AW, default 8: twiddle ROM address width.
REQ-004 Parameter TW_STRIDE, default 1: twiddle address step per butterfly.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input sample present this cycle.
REQ-008 flush  in  1  request drain of last frame's subtraction results.
REQ-009 in_ready  out  1  sample accepted when in_valid & in_ready.
REQ-010 rd_addr  out  log2(N_HALF)  delay-buffer read address (read-before-write memory).
REQ-011 wa_en / wa_addr  out  1 / log2(N_HALF)  port A write: store input sample.
REQ-012 wb_en / wb_addr  out  1 / log2(N_HALF)  port B write: store BFU sub result.
REQ-013 bfu_issue  out  1  a = buffer read data, b = input; launch butterfly.
REQ-014 tw_addr  out  TW_AW  twiddle address, valid with bfu_issue, else 0.
REQ-015 out_valid / out_sel  out  1 / 1  output sample valid; sel 0 = buffer read data delayed BFU_LAT, 1 = BFU add result.
REQ-016 busy  out  1  state != IDLE or any in-flight pipeline entry.

Function
REQ-017 States IDLE, FILL, BFLY, DRAIN; sample counter cnt (log2(N_HALF)+1 bits), k = cnt low bits.
REQ-018 in_ready SHALL be 1 in IDLE/FILL/BFLY, 0 in DRAIN; cnt advances only on accepted sample; wrap 2*N_HALF-1 -> 0.
REQ-019 IDLE: accepted sample -> wa_en=1, wa_addr=0, cnt=1, go FILL; have_prev=0.
REQ-020 FILL (cnt<N_HALF), accepted sample: wa_en=1, wa_addr=k, rd_addr=k; if have_prev, push {valid=1, sel=0} into output pipeline; at k=N_HALF-1 go BFLY.
REQ-021 BFLY, accepted sample: rd_addr=k, bfu_issue=1, tw_addr=(k*TW_STRIDE) mod 2^TW_AW, push {valid=1, sel=1, addr=k}; at k=N_HALF-1 go FILL, set have_prev=1.
REQ-022 Output pipeline SHALL be exactly BFU_LAT stages, advancing every clock regardless of in_valid gaps; out_valid/out_sel = stage BFU_LAT output.
REQ-023 Writeback: when sel=1 entry exits pipeline, wb_en=1, wb_addr=its addr, same cycle as out_valid.
REQ-024 wa and wb in same cycle SHALL target different addresses (guaranteed by N_HALF > BFU_LAT); no arbitration needed.
REQ-025 Flush: honoured only in FILL with cnt=0, have_prev=1, in_valid=0 -> DRAIN; otherwise ignored; in_valid with flush same cycle: sample wins, flush ignored.
REQ-026 DRAIN: one entry per clock, rd_addr=0..N_HALF-1, push {1, 0}, no writes; after N_HALF cycles go IDLE, cnt=0, have_prev=0.
REQ-027 Gaps: no sample -> no pushes, no writes from port A, no bfu_issue; state held.
REQ-028 Output order per frame: N_HALF add results (sel=1), then next frame's FILL (or DRAIN) emits N_HALF sub results (sel=0) in k order.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cnt=0, have_prev=0, pipeline cleared; all outputs 0 except in_ready=1.
REQ-030 Reset mid-frame SHALL discard all in-flight butterflies; no wb_en/out_valid until new issues.

Verification
REQ-031 16 back-to-back samples from reset -> wa_en cycles 0-7 addr 0-7; bfu_issue cycles 8-15, tw_addr 0-7; out_valid sel=1 cycles 12-19; wb_en cycles 12-19 addr 0-7.
REQ-032 24 continuous samples -> sel=0 outputs cycles 20-27 (sub results k 0-7) immediately after adds; no gaps, no two-valid collisions.
REQ-033 16 samples then flush at cnt=0 -> DRAIN 8 cycles, sel=0 outputs 8 cycles after entry, then IDLE, busy falls after last out_valid.
REQ-034 in_valid gap of 3 cycles mid-BFLY -> tw_addr/out sequence unchanged, outputs shifted by 3, pipeline spacing preserved.
REQ-035 rst_n asserted during BFLY k=5 -> all outputs 0 async, no out_valid after release until new frame's adds.
REQ-036 TW_STRIDE=32, TW_AW=8 -> tw_addr 0,32,...,224, then wraps to 0 next frame.
